// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates fetch (I) and data (D) requesters onto one path and
// sequences either the internal sync RAM or the external wait-state bus, then acks the winner.
module mem_access_ctrl #(
    parameter logic [15:0] INT_BASE = 16'h0500,
    parameter logic [15:0] INT_LAST = 16'h08FF,
    parameter int unsigned EXT_WAIT = 3,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq,
    input  logic [15:0] iaddr,
    output logic        iack,
    output logic [31:0] irdata,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [15:0] daddr,
    input  logic [31:0] dwdata,
    output logic        dack,
    output logic [31:0] drdata,
    output logic        derr,
    output logic        ierr,
    output logic        intcs_n,
    output logic        intwe,
    output logic [9:0]  intaddr,
    output logic [31:0] intwdata,
    input  logic [31:0] intrdata,
    output logic        extreq,
    output logic        extwe,
    output logic [15:0] extaddr,
    output logic [31:0] extwdata,
    input  logic [31:0] extrdata,
    input  logic        extrdy,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INT_ACC = 2'd1,
        EXT_ACC = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state_reg;
    logic        last_d_reg;
    logic        sel_d_reg;
    logic        we_reg;
    logic        int_sel_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] irdata_reg;
    logic [31:0] drdata_reg;

    logic        gnt_d;
    logic [15:0] req_addr;
    logic        req_we;
    logic        req_int;
    logic [9:0]  req_off;
    logic        ext_done;
    logic        ext_tmo;
    logic        int_rd_resp;

    // On a tie the side that did not win last time is granted.
    assign gnt_d    = dreq & (~ireq | ~last_d_reg);
    assign req_addr = gnt_d ? daddr : iaddr;
    assign req_we   = gnt_d & dwe;
    assign req_int  = (req_addr >= INT_BASE) && (req_addr <= INT_LAST);
    assign req_off  = 10'(req_addr - INT_BASE);

    assign ext_done = (cnt_reg >= 8'(EXT_WAIT)) && extrdy;
    assign ext_tmo  = (cnt_reg == 8'(TIMEOUT));

    // Sync RAM data only appears in the response cycle, so it is forwarded while acked
    // and captured into the holding register at the end of that cycle.
    assign int_rd_resp = (state_reg == RESP) && int_sel_reg && !we_reg;
    assign irdata      = (int_rd_resp && !sel_d_reg) ? intrdata : irdata_reg;
    assign drdata      = (int_rd_resp &&  sel_d_reg) ? intrdata : drdata_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            last_d_reg  <= 1'b0;
            sel_d_reg   <= 1'b0;
            we_reg      <= 1'b0;
            int_sel_reg <= 1'b0;
            cnt_reg     <= 8'd0;
            irdata_reg  <= 32'd0;
            drdata_reg  <= 32'd0;
            iack        <= 1'b0;
            dack        <= 1'b0;
            ierr        <= 1'b0;
            derr        <= 1'b0;
            intcs_n     <= 1'b1;
            intwe       <= 1'b0;
            intaddr     <= 10'd0;
            intwdata    <= 32'd0;
            extreq      <= 1'b0;
            extwe       <= 1'b0;
            extaddr     <= 16'd0;
            extwdata    <= 32'd0;
            busy        <= 1'b0;
        end else begin
            iack <= 1'b0;
            dack <= 1'b0;
            ierr <= 1'b0;
            derr <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ireq || dreq) begin
                        sel_d_reg   <= gnt_d;
                        last_d_reg  <= gnt_d;
                        we_reg      <= req_we;
                        int_sel_reg <= req_int;
                        busy        <= 1'b1;
                        if (req_int) begin
                            state_reg <= INT_ACC;
                            intcs_n   <= 1'b0;
                            intwe     <= req_we;
                            intaddr   <= req_off;
                            intwdata  <= dwdata;
                        end else begin
                            state_reg <= EXT_ACC;
                            cnt_reg   <= 8'd0;
                            extreq    <= 1'b1;
                            extwe     <= req_we;
                            extaddr   <= req_addr;
                            extwdata  <= dwdata;
                        end
                    end
                end
                INT_ACC: begin
                    intcs_n   <= 1'b1;
                    intwe     <= 1'b0;
                    state_reg <= RESP;
                    dack      <= sel_d_reg;
                    iack      <= ~sel_d_reg;
                end
                EXT_ACC: begin
                    if (ext_done || ext_tmo) begin
                        extreq    <= 1'b0;
                        extwe     <= 1'b0;
                        state_reg <= RESP;
                        dack      <= sel_d_reg;
                        iack      <= ~sel_d_reg;
                        // Completion wins over timeout when both hold in the same cycle.
                        if (ext_done) begin
                            if (!we_reg) begin
                                if (sel_d_reg) drdata_reg <= extrdata;
                                else           irdata_reg <= extrdata;
                            end
                        end else begin
                            derr <= sel_d_reg;
                            ierr <= ~sel_d_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    if (int_rd_resp) begin
                        if (sel_d_reg) drdata_reg <= intrdata;
                        else           irdata_reg <= intrdata;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
